// File: rtl/lcd_char_driver.sv
// HD44780 16x2 write-only driver: power-up wait, init, then endless refresh of two snapshotted rows.
// Registered outputs, one byte every 1+E_HIGH_CYC+wait clocks; no input backpressure (text sampled once per frame).
module lcd_char_driver #(
   parameter int unsigned PWRUP_CYC    = 750000,
   parameter int unsigned E_HIGH_CYC   = 25,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 82000,
   parameter int unsigned GAP_CYC      = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] line_1,
   input  logic [127:0] line_2,
   output logic         lcd_e,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_data,
   output logic         init_done,
   output logic         frame_done
);

   localparam int unsigned MAX_AB  = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
   localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > GAP_CYC) ? CMD_WAIT_CYC : GAP_CYC;
   localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_CYC = (MAX_ABC > E_HIGH_CYC) ? MAX_ABC : E_HIGH_CYC;
   localparam int          CW      = (MAX_CYC <= 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
   localparam logic [CW-1:0] E_LAST     = CW'(E_HIGH_CYC - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
   localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST   = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_FRAME_START, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_GAP
   } state_t;

   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

   state_t        state, state_n;
   phase_t        phase, phase_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    idx, idx_n;
   logic [127:0]  shadow_1, shadow_2;
   logic          start, latch, init_set, frame_pulse, e_n, rs_n;
   logic [7:0]    byte_n;
   logic [CW-1:0] hold_last;

   function automatic logic [7:0] init_cmd(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h38;
         4'd1:    return 8'h0C;
         4'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   function automatic logic [7:0] col_char(input logic [127:0] l, input logic [3:0] c);
      return l[{~c, 3'b000} +: 8];
   endfunction

   function automatic logic is_byte_state(input state_t s);
      return (s == S_INIT) || (s == S_ADDR1) || (s == S_LINE1) ||
             (s == S_ADDR2) || (s == S_LINE2);
   endfunction

   assign lcd_rw = 1'b0;

   always_comb begin
      state_n     = state;
      phase_n     = phase;
      cnt_n       = cnt;
      idx_n       = idx;
      start       = 1'b0;
      latch       = 1'b0;
      init_set    = 1'b0;
      frame_pulse = 1'b0;
      rs_n        = 1'b0;
      byte_n      = 8'h00;
      hold_last   = (state == S_INIT && idx == 4'd3) ? CLR_LAST : CMD_LAST;

      case (state)
         S_PWRUP: begin
            if (cnt == PWRUP_LAST) begin
               state_n = S_INIT;
               idx_n   = 4'd0;
               cnt_n   = '0;
               start   = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_FRAME_START: begin
            latch   = 1'b1;
            state_n = S_ADDR1;
            idx_n   = 4'd0;
            cnt_n   = '0;
            start   = 1'b1;
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = S_FRAME_START;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            case (phase)
               PH_SETUP: begin
                  phase_n = PH_PULSE;
                  cnt_n   = '0;
               end
               PH_PULSE: begin
                  if (cnt == E_LAST) begin
                     phase_n = PH_HOLD;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
               default: begin
                  if (cnt == hold_last) begin
                     cnt_n = '0;
                     start = 1'b1;
                     case (state)
                        S_INIT: begin
                           if (idx == 4'd3) begin
                              start    = 1'b0;
                              init_set = 1'b1;
                              state_n  = S_FRAME_START;
                           end else begin
                              idx_n = idx + 4'd1;
                           end
                        end
                        S_ADDR1: begin
                           state_n = S_LINE1;
                           idx_n   = 4'd0;
                        end
                        S_LINE1: begin
                           if (idx == 4'd15) begin
                              state_n = S_ADDR2;
                              idx_n   = 4'd0;
                           end else begin
                              idx_n = idx + 4'd1;
                           end
                        end
                        S_ADDR2: begin
                           state_n = S_LINE2;
                           idx_n   = 4'd0;
                        end
                        default: begin
                           if (idx == 4'd15) begin
                              start       = 1'b0;
                              frame_pulse = 1'b1;
                              state_n     = (GAP_CYC == 0) ? S_FRAME_START : S_GAP;
                           end else begin
                              idx_n = idx + 4'd1;
                           end
                        end
                     endcase
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
            endcase
         end
      endcase

      if (start) begin
         phase_n = PH_SETUP;
      end

      // Byte for the next SETUP; shadow is already valid since FRAME_START precedes ADDR1.
      case (state_n)
         S_INIT:  byte_n = init_cmd(idx_n);
         S_ADDR1: byte_n = 8'h80;
         S_LINE1: begin
            rs_n   = 1'b1;
            byte_n = col_char(shadow_1, idx_n);
         end
         S_ADDR2: byte_n = 8'hC0;
         S_LINE2: begin
            rs_n   = 1'b1;
            byte_n = col_char(shadow_2, idx_n);
         end
         default: byte_n = 8'h00;
      endcase

      e_n = is_byte_state(state_n) && (phase_n == PH_PULSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_PWRUP;
         phase      <= PH_SETUP;
         cnt        <= '0;
         idx        <= 4'd0;
         shadow_1   <= '0;
         shadow_2   <= '0;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         phase      <= phase_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         lcd_e      <= e_n;
         frame_done <= frame_pulse;
         if (start) begin
            lcd_rs   <= rs_n;
            lcd_data <= byte_n;
         end
         if (latch) begin
            shadow_1 <= line_1;
            shadow_2 <= line_2;
         end
         if (init_set) begin
            init_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: two instances (no gap / 10-cycle gap) checked every cycle
// against a time-indexed model of the expected bus, with random text and a mid-frame reset.
module tb_lcd_char_driver;

   localparam int PW       = 20;
   localparam int EH       = 2;
   localparam int CMDW     = 5;
   localparam int CLRW     = 12;
   localparam int BL       = 1 + EH + CMDW;
   localparam int INIT_END = PW + 3 * BL + (1 + EH + CLRW);
   localparam int BODY     = 34 * BL;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] line_1, line_2;

   logic         e0, rs0, rw0, id0, fd0;
   logic [7:0]   d0;
   logic         e1, rs1, rw1, id1, fd1;
   logic [7:0]   d1;

   int n_checks = 0;
   int n_errors = 0;
   int t        = 0;
   logic armed  = 1'b0;

   logic [127:0] sh1 [2];
   logic [127:0] sh2 [2];
   int   hi_len [2];
   logic prev_e [2];
   logic prev_idn [2];
   logic seen_rise [2];
   int   last_fd [2];

   always #5 clk = ~clk;

   lcd_char_driver #(
      .PWRUP_CYC(PW), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CMDW),
      .CLR_WAIT_CYC(CLRW), .GAP_CYC(0)
   ) dut_g0 (
      .clk(clk), .rst(rst), .line_1(line_1), .line_2(line_2),
      .lcd_e(e0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(d0),
      .init_done(id0), .frame_done(fd0)
   );

   lcd_char_driver #(
      .PWRUP_CYC(PW), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CMDW),
      .CLR_WAIT_CYC(CLRW), .GAP_CYC(10)
   ) dut_g10 (
      .clk(clk), .rst(rst), .line_1(line_1), .line_2(line_2),
      .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(d1),
      .init_done(id1), .frame_done(fd1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
      end
   endtask

   function automatic logic [7:0] col(input logic [127:0] s, input int k);
      return s[127 - 8 * k -: 8];
   endfunction

   // Expected {rw, e, rs, data, init_done, frame_done} for t clocks after reset.
   function automatic logic [12:0] model_out(input int tt, input int gap,
                                             input logic [127:0] s1, input logic [127:0] s2);
      logic e, rs, idn, fd;
      logic [7:0] d;
      int o, i, off, u, f, b, per;
      e = 1'b0; rs = 1'b0; d = 8'h00; idn = 1'b0; fd = 1'b0;
      per = 1 + BODY + gap;
      if (tt >= PW && tt < INIT_END) begin
         o   = tt - PW;
         i   = (o < 3 * BL) ? o / BL : 3;
         off = o - i * BL;
         case (i)
            0:       d = 8'h38;
            1:       d = 8'h0C;
            2:       d = 8'h06;
            default: d = 8'h01;
         endcase
         e = (off >= 1 && off <= EH);
      end else if (tt >= INIT_END) begin
         idn = 1'b1;
         u   = (tt - INIT_END) % per;
         f   = (tt - INIT_END) / per;
         if (u == 0 || u > BODY) begin
            if (u == 0 && f == 0) d = 8'h01;
            else begin
               d  = col(s2, 15);
               rs = 1'b1;
            end
            fd = (gap == 0) ? (u == 0 && f > 0) : (u == BODY + 1);
         end else begin
            b   = (u - 1) / BL;
            off = (u - 1) % BL;
            e   = (off >= 1 && off <= EH);
            if (b == 0) d = 8'h80;
            else if (b <= 16) begin
               rs = 1'b1;
               d  = col(s1, b - 1);
            end else if (b == 17) d = 8'hC0;
            else begin
               rs = 1'b1;
               d  = col(s2, b - 18);
            end
         end
      end
      return {1'b0, e, rs, d, idn, fd};
   endfunction

   task automatic mon(input int k, input int gap, input logic [12:0] obs);
      logic [12:0] exp;
      int per;
      per = 1 + BODY + gap;
      if (t == 0) begin
         hi_len[k] = 0; prev_e[k] = 1'b0; prev_idn[k] = 1'b0;
         seen_rise[k] = 1'b0; last_fd[k] = -1;
      end
      exp = model_out(t, gap, sh1[k], sh2[k]);
      check_val((k == 0) ? "bus_gap0" : "bus_gap10", 32'(obs), 32'(exp));
      if (obs[11]) hi_len[k]++;
      else if (prev_e[k]) begin
         check_val("e_width", hi_len[k], EH);
         hi_len[k] = 0;
      end
      if (obs[11] && !prev_e[k] && !seen_rise[k]) begin
         check_val("first_e_rise", t, PW + 1);
         seen_rise[k] = 1'b1;
      end
      prev_e[k] = obs[11];
      if (obs[1] && !prev_idn[k]) check_val("init_rise", t, INIT_END);
      prev_idn[k] = obs[1];
      if (obs[0]) begin
         if (last_fd[k] < 0) check_val("fd_first", t, INIT_END + BODY + 1);
         else check_val("fd_space", t - last_fd[k], per);
         last_fd[k] = t;
      end
      if (t >= INIT_END && (t - INIT_END) % per == 0) begin
         sh1[k] = line_1;
         sh2[k] = line_2;
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         t     <= 0;
         armed <= 1'b1;
      end else begin
         t <= t + 1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         mon(0, 0,  {rw0, e0, rs0, d0, id0, fd0});
         mon(1, 10, {rw1, e1, rs1, d1, id1, fd1});
      end
   end

   task automatic wait_to(input int target);
      while (t < target) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic random_text();
      line_1 = {$urandom, $urandom, $urandom, $urandom};
      line_2 = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int f, target;
      rst    = 1'b1;
      line_1 = "   Game Start   ";
      line_2 = "                ";
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;

      // Mid-frame change at LINE1 column 5 must wait for the next frame.
      wait_to(INIT_END + 1 + 6 * BL + 3);
      line_1 = "     Fail...    ";
      wait_to(INIT_END + 2 * (1 + BODY) + 5);

      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(20, 300)) @(posedge clk);
         #2;
         random_text();
      end

      // Reset while lcd_e is high on a LINE2 byte of the gap-free instance.
      f      = (t - INIT_END) / (1 + BODY);
      target = INIT_END + (f + 1) * (1 + BODY) + 1 + BL * (18 + int'($urandom_range(0, 15))) + 1;
      wait_to(target);
      check_val("e_before_rst", 32'(e0), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(50, 250)) @(posedge clk);
         #2;
         random_text();
      end
      wait_to(INIT_END + 3 * (1 + BODY + 10) + 20);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
